xnor_popcount_conv3x3: RTL and testbench

Binary convolution stage that consumes the 3x3 binary patch stream produced by the 28x28 patch extractor. For each incoming patch it computes, for NUM_FILTERS filters in parallel, the XNOR match count against a stored 3x3 binary kernel. It also produces the popcount, the binarized activation (popcount >= per-filter threshold), and the output-map coordinates. It feeds the next BCNN layer or pooling stage through a fixed-latency 3-stage pipeline.

---
 rtl/xnor_popcount_conv3x3_if.sv | 33 +++
 rtl/xnor_popcount_conv3x3.sv | 88 ++++++++
 tb/tb_xnor_popcount_conv3x3.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/xnor_popcount_conv3x3_if.sv
// xnor_popcount_conv3x3_if: patch stream, filter configuration and result bundle of the binary conv stage
interface xnor_popcount_conv3x3_if #(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 4
);
  localparam int PATCH_SIZE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT_W      = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H      = IMG_HEIGHT - KERNEL_SIZE + 1;
  localparam int CW         = $clog2(PATCH_SIZE + 1);
  localparam int FW         = $clog2(NUM_FILTERS);
  logic [PATCH_SIZE-1:0]     patch_in;
  logic                      valid_in;
  logic                      cfg_we;
  logic [FW-1:0]             cfg_sel;
  logic [PATCH_SIZE-1:0]     cfg_weight;
  logic [CW-1:0]             cfg_thresh;
  logic [NUM_FILTERS*CW-1:0] popcnt_out;
  logic [NUM_FILTERS-1:0]    act_out;
  logic                      valid_out;
  logic [$clog2(OUT_W)-1:0]  out_col;
  logic [$clog2(OUT_H)-1:0]  out_row;
  logic                      frame_done;
  modport master (
    output patch_in, valid_in, cfg_we, cfg_sel, cfg_weight, cfg_thresh,
    input  popcnt_out, act_out, valid_out, out_col, out_row, frame_done
  );
  modport slave (
    input  patch_in, valid_in, cfg_we, cfg_sel, cfg_weight, cfg_thresh,
    output popcnt_out, act_out, valid_out, out_col, out_row, frame_done
  );
endinterface

// File: rtl/xnor_popcount_conv3x3.sv
// xnor_popcount_conv3x3: 3-stage XNOR/popcount/threshold binary convolution over a 3x3 patch stream
module xnor_popcount_conv3x3 #(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 4
) (
  input logic                   clk,
  input logic                   reset,
  xnor_popcount_conv3x3_if.slave bus
);
  localparam int PS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT_W = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;
  localparam int CW    = $clog2(PS + 1);
  localparam int FW    = $clog2(NUM_FILTERS);
  localparam int XW    = $clog2(OUT_W);
  localparam int YW    = $clog2(OUT_H);
  logic [PS-1:0]             weight_q [NUM_FILTERS];
  logic [CW-1:0]             thresh_q [NUM_FILTERS];
  logic [PS-1:0]             xnor_q   [NUM_FILTERS];
  logic [CW-1:0]             cnt_q    [NUM_FILTERS];
  logic [CW-1:0]             cnt_d    [NUM_FILTERS];
  logic                      v1_q, v2_q, valid_q, frame_q;
  logic [NUM_FILTERS*CW-1:0] popcnt_q;
  logic [NUM_FILTERS-1:0]    act_q;
  logic [XW-1:0]             col_q, out_col_q;
  logic [YW-1:0]             row_q, out_row_q;
  logic                      col_end, last_pos;
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      cnt_d[f] = '0;
      for (int i = 0; i < PS; i++) cnt_d[f] = cnt_d[f] + CW'(xnor_q[f][i]);
    end
  end
  assign col_end  = col_q == XW'(OUT_W - 1);
  assign last_pos = col_end && row_q == YW'(OUT_H - 1);
  // col_q/row_q hold the position of the next valid result; they move only when one is registered
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        weight_q[f] <= '0;
        thresh_q[f] <= CW'((PS + 1) / 2);
        xnor_q[f]   <= '0;
        cnt_q[f]    <= '0;
      end
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      popcnt_q  <= '0;
      act_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      v1_q    <= bus.valid_in;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      frame_q <= v2_q && last_pos;
      for (int f = 0; f < NUM_FILTERS; f++) begin
        xnor_q[f] <= ~(bus.patch_in ^ weight_q[f]);
        cnt_q[f]  <= cnt_d[f];
        if (bus.cfg_we && bus.cfg_sel == FW'(f)) begin
          weight_q[f] <= bus.cfg_weight;
          thresh_q[f] <= bus.cfg_thresh;
        end
        if (v2_q) begin
          popcnt_q[f*CW +: CW] <= cnt_q[f];
          act_q[f]             <= cnt_q[f] >= thresh_q[f];
        end
      end
      if (v2_q) begin
        out_col_q <= col_q;
        out_row_q <= row_q;
        col_q     <= col_end ? '0 : col_q + XW'(1);
        row_q     <= last_pos ? '0 : (col_end ? row_q + YW'(1) : row_q);
      end
    end
  end
  assign bus.popcnt_out = popcnt_q;
  assign bus.act_out    = act_q;
  assign bus.valid_out  = valid_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_row    = out_row_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_xnor_popcount_conv3x3.sv
// tb_xnor_popcount_conv3x3: random and directed stimulus checked against a cycle-level behavioural model
module tb_xnor_popcount_conv3x3;
  localparam int NF = 4, PS = 9, CW = 4, OW = 26, OH = 26;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  xnor_popcount_conv3x3_if bus ();
  xnor_popcount_conv3x3 dut (.clk(clk), .reset(reset), .bus(bus));

  int nchk = 0, nfail = 0, vcount = 0, fcount = 0;
  logic [PS-1:0] mw [NF];
  int mt [NF];
  logic pv [2];
  logic [PS-1:0] pp [2];
  logic [PS-1:0] pw [2][NF];
  logic e_valid = 1'b0, e_frame = 1'b0;
  logic [NF*CW-1:0] e_pop = '0;
  logic [NF-1:0] e_act = '0;
  int e_col = 0, e_row = 0, nres = 0, p;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a patch is captured with the weights current at its sampling edge and
  // judged against the thresholds current at the third edge after that.
  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      pv[0] = 1'b0; pv[1] = 1'b0;
      e_valid = 1'b0; e_frame = 1'b0; e_pop = '0; e_act = '0; nres = 0;
      for (int f = 0; f < NF; f++) begin mw[f] = '0; mt[f] = (PS + 1) / 2; end
    end else if (started) begin
      e_valid = pv[1];
      e_frame = 1'b0;
      if (pv[1]) begin
        for (int f = 0; f < NF; f++) begin
          p = $countones(~(pp[1] ^ pw[1][f]));
          e_pop[f*CW +: CW] = CW'(p);
          e_act[f] = p >= mt[f];
        end
        e_col = nres % OW;
        e_row = (nres / OW) % OH;
        e_frame = (nres % (OW * OH)) == OW * OH - 1;
        nres++;
      end
      pv[1] = pv[0]; pp[1] = pp[0]; pw[1] = pw[0];
      pv[0] = bus.valid_in; pp[0] = bus.patch_in;
      for (int f = 0; f < NF; f++) pw[0][f] = mw[f];
      if (bus.cfg_we && int'(bus.cfg_sel) < NF) begin
        mw[bus.cfg_sel] = bus.cfg_weight;
        mt[bus.cfg_sel] = int'(bus.cfg_thresh);
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("valid_out", bus.valid_out, e_valid);
    chk("frame_done", bus.frame_done, e_frame);
    chk("popcnt_out", bus.popcnt_out, e_pop);
    chk("act_out", bus.act_out, e_act);
    if (e_valid) begin
      chk("out_col", bus.out_col, e_col);
      chk("out_row", bus.out_row, e_row);
    end
    if (bus.valid_out) vcount++;
    if (bus.frame_done) fcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    bus.cfg_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input int sel, input logic [PS-1:0] w, input int t);
    bus.cfg_we = 1'b1;
    bus.cfg_sel = 2'(sel);
    bus.cfg_weight = w;
    bus.cfg_thresh = CW'(t);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic probe(input string name, input logic [PS-1:0] patch, input logic [15:0] ep,
                       input logic [3:0] ea, input int ec, input int er);
    bus.valid_in = 1'b1;
    bus.patch_in = patch;
    tick();
    bus.valid_in = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk({name, "_valid"}, bus.valid_out, 1'b1);
    chk({name, "_pop"}, bus.popcnt_out, ep);
    chk({name, "_act"}, bus.act_out, ea);
    chk({name, "_col"}, bus.out_col, ec);
    chk({name, "_row"}, bus.out_row, er);
    tick();
  endtask

  initial begin
    int v0, f0;
    logic [4:0] pat;
    logic [7:0] got;
    bus.valid_in = 1'b0; bus.patch_in = '0;
    bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_weight = '0; bus.cfg_thresh = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    probe("rst_1ff", 9'h1FF, 16'h0000, 4'h0, 0, 0);
    probe("rst_000", 9'h000, 16'h9999, 4'hF, 1, 0);
    cfg(2, 9'h155, 9);
    probe("f2_155", 9'h155, 16'h4944, 4'b0100, 2, 0);
    probe("f2_0aa", 9'h0AA, 16'h5055, 4'b1011, 3, 0);
    cfg(0, 9'h000, 0);
    probe("th0", 9'h1FF, 16'h0500, 4'b0001, 4, 0);
    cfg(0, 9'h000, 10);
    probe("th10", 9'h000, 16'h9499, 4'b1010, 5, 0);
    cfg(0, 9'h000, 4);
    probe("th4_eq", 9'h1F0, 16'h4544, 4'b0001, 6, 0);
    probe("th4_lt", 9'h1F8, 16'h3433, 4'b0000, 7, 0);

    do_reset();
    v0 = vcount; f0 = fcount;
    for (int i = 0; i < OW * OH; i++) begin
      bus.valid_in = 1'b1;
      bus.patch_in = PS'($urandom);
      tick();
    end
    idle(5);
    chk("frame_results", vcount - v0, OW * OH);
    chk("frame_done_cnt", fcount - f0, 1);
    for (int i = 0; i < 30; i++) begin
      bus.valid_in = 1'b1;
      bus.patch_in = PS'($urandom);
      tick();
    end
    idle(5);

    pat = 5'b11001;
    for (int i = 0; i < 8; i++) begin
      bus.valid_in = i < 5 ? pat[i] : 1'b0;
      bus.patch_in = PS'($urandom);
      @(negedge clk);
      got[i] = bus.valid_out;
      tick();
    end
    chk("bubbles", got, 8'b1100_1000);
    idle(4);

    do_reset();
    for (int i = 0; i < 103; i++) begin
      bus.valid_in = 1'b1;
      bus.patch_in = PS'($urandom);
      tick();
    end
    bus.valid_in = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = vcount;
    idle(5);
    chk("no_stale", vcount - v0, 0);
    probe("post_rst", 9'h000, 16'h9999, 4'hF, 0, 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.valid_in = $urandom_range(0, 3) != 0;
      bus.patch_in = PS'($urandom);
      bus.cfg_we = $urandom_range(0, 31) == 0;
      bus.cfg_sel = 2'($urandom_range(0, NF - 1));
      bus.cfg_weight = PS'($urandom);
      bus.cfg_thresh = CW'($urandom_range(0, 15));
      tick();
    end
    bus.cfg_we = 1'b0;
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
